// File: rtl/vslc_pkg.sv
// Shared types and header layout for the VSLC scan sequencer.
package vslc_pkg;

    typedef enum logic [1:0] {
        SCAN_CONT     = 2'd0,
        SCAN_TRIG     = 2'd1,
        SCAN_PERIODIC = 2'd2,
        SCAN_HALT     = 2'd3
    } scan_mode_t;

    typedef enum logic [1:0] {
        HDR,
        WAIT,
        RUN,
        ERR
    } seq_state_t;

    // Header is big-endian: start_addr in bytes 0..1, end_addr in bytes 2..3.
    localparam int unsigned HDR_BYTES    = 4;
    localparam int unsigned HDR_START_HI = 0;
    localparam int unsigned HDR_START_LO = 1;
    localparam int unsigned HDR_END_HI   = 2;
    localparam int unsigned HDR_END_LO   = 3;

endpackage

// File: rtl/vslc_scan_trigger.sv
// Scan request generation: trigger synchroniser and edge detect, periodic
// tick divider, single-entry pending request and sticky overrun flag.
module vslc_scan_trigger
    import vslc_pkg::*;
#(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  scan_mode_t       mode,
    input  logic [PER_W-1:0] period,
    input  logic             tick,
    input  logic             trig_in,
    input  logic             cnt_en,
    input  logic             in_wait,
    input  logic             scan_start,
    input  logic             hdr_done,
    output logic             scan_req,
    output logic             overrun
);

    logic             trig_s1, trig_s2, trig_s3;
    logic [PER_W-1:0] tick_cnt;
    logic [PER_W-1:0] per_eff;
    logic             trig_edge;
    logic             tick_wrap;
    logic             new_req;
    logic             req_pending;

    assign per_eff   = (period == '0) ? PER_W'(1) : period;
    // >= rather than == so a shortened period wraps at once instead of overflowing
    assign tick_wrap = tick && (tick_cnt >= per_eff - PER_W'(1));
    assign trig_edge = trig_s2 & ~trig_s3;

    always_comb begin
        new_req = 1'b0;
        if (cnt_en) begin
            case (mode)
                SCAN_CONT:     new_req = in_wait;
                SCAN_TRIG:     new_req = trig_edge;
                SCAN_PERIODIC: new_req = tick_wrap;
                default:       new_req = 1'b0;
            endcase
        end
    end

    assign scan_req = req_pending | new_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1     <= 1'b0;
            trig_s2     <= 1'b0;
            trig_s3     <= 1'b0;
            tick_cnt    <= '0;
            req_pending <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
            if (cnt_en && tick) begin
                tick_cnt <= tick_wrap ? '0 : tick_cnt + PER_W'(1);
            end
            if (hdr_done) begin
                req_pending <= 1'b1;
            end else if (scan_start) begin
                req_pending <= 1'b0;
            end else if (new_req) begin
                if (req_pending) begin
                    overrun <= 1'b1;
                end else begin
                    req_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vslc_scan_sequencer.sv
// Program-fetch and scan-cycle controller: parses the program header, paces
// scans and forwards in-range program bytes to the executor with framing.
module vslc_scan_sequencer
    import vslc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned N_IN   = 8,
    parameter int unsigned PER_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [PER_W-1:0]  period,
    input  logic              tick,
    input  logic              trig_in,
    input  logic [N_IN-1:0]   ui_in,
    output logic              rd_restart,
    output logic [ADDR_W-1:0] rd_start_addr,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              instr_valid,
    output logic [7:0]        instr_data,
    output logic              instr_first,
    output logic              instr_last,
    output logic [N_IN-1:0]   in_now,
    output logic [N_IN-1:0]   in_prev,
    output logic              scan_pulse,
    output logic [15:0]       scan_cnt,
    output logic              busy,
    output logic              header_err,
    output logic              overrun
);

    seq_state_t        state;
    scan_mode_t        mode_e;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] hdr_field;
    logic [7:0]        hdr_hi;
    logic              booted;
    logic              hdr_last;
    logic              hdr_done;
    logic              scan_req;
    logic              scan_start;
    logic              in_range;

    assign mode_e     = scan_mode_t'(mode);
    assign hdr_field  = ADDR_W'({hdr_hi, rd_data});
    assign hdr_last   = (state == HDR) && rd_valid && (rd_addr == ADDR_W'(HDR_END_LO));
    assign hdr_done   = hdr_last && !((hdr_field < start_addr) || (hdr_field < ADDR_W'(HDR_BYTES)));
    assign scan_start = (state == WAIT) && scan_req && (mode_e != SCAN_HALT);
    assign in_range   = (rd_addr >= start_addr) && (rd_addr <= end_addr);

    vslc_scan_trigger #(
        .PER_W(PER_W)
    ) u_trigger (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_e),
        .period    (period),
        .tick      (tick),
        .trig_in   (trig_in),
        .cnt_en    ((state == WAIT) || (state == RUN)),
        .in_wait   (state == WAIT),
        .scan_start(scan_start),
        .hdr_done  (hdr_done),
        .scan_req  (scan_req),
        .overrun   (overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HDR;
            start_addr    <= '0;
            end_addr      <= '0;
            hdr_hi        <= '0;
            booted        <= 1'b0;
            rd_restart    <= 1'b0;
            rd_start_addr <= '0;
            instr_valid   <= 1'b0;
            instr_data    <= '0;
            instr_first   <= 1'b0;
            instr_last    <= 1'b0;
            in_now        <= '0;
            in_prev       <= '0;
            scan_pulse    <= 1'b0;
            scan_cnt      <= '0;
            busy          <= 1'b0;
            header_err    <= 1'b0;
        end else begin
            rd_restart  <= 1'b0;
            scan_pulse  <= 1'b0;
            instr_valid <= 1'b0;
            instr_first <= 1'b0;
            instr_last  <= 1'b0;
            // One restart from address 0 right after reset release starts the header fetch
            if (!booted) begin
                booted        <= 1'b1;
                rd_restart    <= 1'b1;
                rd_start_addr <= '0;
            end
            case (state)
                HDR: begin
                    if (rd_valid) begin
                        if (rd_addr == ADDR_W'(HDR_START_HI) || rd_addr == ADDR_W'(HDR_END_HI)) begin
                            hdr_hi <= rd_data;
                        end else if (rd_addr == ADDR_W'(HDR_START_LO)) begin
                            start_addr <= hdr_field;
                        end else if (hdr_last) begin
                            end_addr <= hdr_field;
                            if (hdr_done) begin
                                state <= WAIT;
                            end else begin
                                state      <= ERR;
                                header_err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (scan_start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        rd_restart    <= 1'b1;
                        rd_start_addr <= start_addr;
                        scan_pulse    <= 1'b1;
                        in_prev       <= in_now;
                        in_now        <= ui_in;
                    end
                end
                RUN: begin
                    if (rd_valid && in_range) begin
                        instr_valid <= 1'b1;
                        instr_data  <= rd_data;
                        instr_first <= (rd_addr == start_addr);
                        instr_last  <= (rd_addr == end_addr);
                        if (rd_addr == end_addr) begin
                            scan_cnt <= scan_cnt + 16'd1;
                            state    <= WAIT;
                            busy     <= 1'b0;
                        end
                    end
                end
                ERR: begin
                    header_err <= 1'b1;
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Randomised bench for vslc_scan_sequencer with a reader model, a program
// image and a scan-level scoreboard of expected byte streams and images.
module tb_vslc_scan_sequencer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned N_IN   = 8;
    localparam int unsigned PER_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [PER_W-1:0]  period;
    logic              tick;
    logic              trig_in;
    logic [N_IN-1:0]   ui_in;
    logic              rd_restart;
    logic [ADDR_W-1:0] rd_start_addr;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic              instr_first;
    logic              instr_last;
    logic [N_IN-1:0]   in_now;
    logic [N_IN-1:0]   in_prev;
    logic              scan_pulse;
    logic [15:0]       scan_cnt;
    logic              busy;
    logic              header_err;
    logic              overrun;

    vslc_scan_sequencer #(
        .ADDR_W(ADDR_W),
        .N_IN  (N_IN),
        .PER_W (PER_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .period       (period),
        .tick         (tick),
        .trig_in      (trig_in),
        .ui_in        (ui_in),
        .rd_restart   (rd_restart),
        .rd_start_addr(rd_start_addr),
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_first  (instr_first),
        .instr_last   (instr_last),
        .in_now       (in_now),
        .in_prev      (in_prev),
        .scan_pulse   (scan_pulse),
        .scan_cnt     (scan_cnt),
        .busy         (busy),
        .header_err   (header_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        mem [0:1023];
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] m_start, m_end, exp_a;
    logic [15:0]       m_cnt;
    logic [N_IN-1:0]   m_now, m_prev, ui_at_edge;
    bit                in_scan, b2b_chk, gaps, ui_rand, tick_on;
    int                idx, scans_done, n_pulse, n_restart, n_instr, cyc, last_end_cyc, tdiv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rd_restart, rd_start_addr, instr_valid, instr_data, instr_first, instr_last,
                    in_now, in_prev, scan_pulse, scan_cnt, busy, header_err, overrun});
    endfunction

    // Reader: streams sequential bytes from the image, jumping on each restart
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rd_valid = 1'b0;
            rptr     = '0;
        end else begin
            if (rd_restart) rptr = rd_start_addr;
            if (!gaps || $urandom_range(0, 3) != 0) begin
                rd_valid = 1'b1;
                rd_addr  = rptr;
                rd_data  = mem[rptr];
                rptr     = rptr + 1'b1;
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        ui_at_edge = ui_in;
        #2;
        if (ui_rand) ui_in = N_IN'($urandom);
        tick = 1'b0;
        if (tick_on) begin
            tdiv++;
            if (tdiv == 10) begin
                tick = 1'b1;
                tdiv = 0;
            end
        end
    end

    // Scoreboard: each scan must deliver mem[start..end] in order, framed
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            in_scan = 0; idx = 0; scans_done = 0; n_pulse = 0; n_restart = 0; n_instr = 0;
            m_cnt = '0; m_now = '0; m_prev = '0;
        end else begin
            if (rd_restart) n_restart++;
            if (scan_pulse) begin
                if (b2b_chk && scans_done > 0) check("b2b_gap", 64'(cyc - last_end_cyc), 64'd1);
                m_prev = m_now;
                m_now  = ui_at_edge;
                check("in_now", in_now, m_now);
                check("in_prev", in_prev, m_prev);
                check("scan_restart", rd_restart, 1);
                check("scan_start_addr", rd_start_addr, m_start);
                check("busy_on", busy, 1);
                in_scan = 1; idx = 0; n_pulse++;
            end
            if (instr_valid) begin
                exp_a = m_start + ADDR_W'(idx);
                check("instr_in_scan", in_scan, 1);
                check("instr_data", instr_data, mem[exp_a]);
                check("instr_first", instr_first, idx == 0);
                check("instr_last", instr_last, exp_a == m_end);
                idx++; n_instr++;
                if (exp_a == m_end) begin
                    in_scan = 0;
                    m_cnt   = m_cnt + 16'd1;
                    scans_done++;
                    last_end_cyc = cyc;
                    check("scan_cnt", scan_cnt, m_cnt);
                    check("busy_off", busy, 0);
                end
            end
        end
    end

    task automatic do_reset(input logic [15:0] hs, input logic [15:0] he);
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0]  = hs[15:8];
        mem[1]  = hs[7:0];
        mem[2]  = he[15:8];
        mem[3]  = he[7:0];
        m_start = hs[ADDR_W-1:0];
        m_end   = he[ADDR_W-1:0];
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_scans(input int n, input int budget);
        for (int i = 0; i < budget && scans_done < n; i++) @(negedge clk);
        check("scan_timeout", scans_done >= n, 1);
    endtask

    initial begin
        logic [15:0] hs, he;
        int r, n, st, len;
        rst_n = 1'b1; mode = 2'd0; period = '0; trig_in = 1'b0; ui_in = '0;
        rd_valid = 1'b0; rd_addr = '0; rd_data = '0; tick = 1'b0;
        gaps = 1; ui_rand = 1; tick_on = 0; b2b_chk = 0; tdiv = 0; cyc = 0;
        #1;

        // Basic continuous scans over 0x10..0x13
        b2b_chk = 1;
        do_reset(16'h0010, 16'h0013);
        for (int i = 0; i < 10 && !rd_restart; i++) @(negedge clk);
        check("boot_restart", rd_restart, 1);
        check("boot_addr", rd_start_addr, 0);
        wait_scans(3, 300);
        check("instr_count", n_instr, 12);

        // Asynchronous reset in the middle of a scan, then header re-parse
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10 && !rd_restart; i++) @(negedge clk);
        check("rst_restart", rd_restart, 1);
        check("rst_restart_addr", rd_start_addr, 0);
        wait_scans(2, 300);

        // Header errors
        b2b_chk = 0;
        do_reset(16'h0020, 16'h0010);
        for (int i = 0; i < 100 && !header_err; i++) @(negedge clk);
        check("hdr_err_order", header_err, 1);
        r = n_restart;
        repeat (1000) @(negedge clk);
        check("err_no_restart", 64'(n_restart - r), 64'd0);
        check("err_no_instr", n_instr, 0);
        check("err_busy", busy, 0);
        do_reset(16'h0000, 16'h0002);
        for (int i = 0; i < 100 && !header_err; i++) @(negedge clk);
        check("hdr_err_short", header_err, 1);

        // External trigger latency and image history
        mode = 2'd1;
        do_reset(16'h0008, 16'h000B);
        wait_scans(1, 100);
        ui_rand = 0;
        ui_in   = 8'h3C;
        @(negedge clk);
        trig_in = 1'b1;
        wait_scans(2, 100);
        trig_in = 1'b0;
        repeat (5) @(negedge clk);
        ui_in = 8'hA5;
        trig_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("trig_lat_early", scan_pulse, 0);
        @(posedge clk);
        #1 check("trig_lat", scan_pulse, 1);
        check("trig_in_now", in_now, 8'hA5);
        check("trig_in_prev", in_prev, 8'h3C);
        wait_scans(3, 100);
        repeat (50) @(negedge clk);
        check("trig_level_held", n_pulse, 3);
        trig_in = 1'b0;
        ui_rand = 1;

        // Periodic mode: requests during a long scan, overrun, then halt
        mode = 2'd2; period = 16'd3; gaps = 0; tick_on = 1; b2b_chk = 1;
        do_reset(16'h0010, 16'h005F);
        for (int i = 0; i < 50 && n_pulse < 1; i++) @(negedge clk);
        check("per_first_overrun", overrun, 0);
        wait_scans(1, 300);
        check("overrun_set", overrun, 1);
        for (int i = 0; i < 10 && n_pulse < 2; i++) @(negedge clk);
        check("per_second_scan", n_pulse, 2);
        mode = 2'd3;
        wait_scans(2, 300);
        r = n_pulse;
        repeat (300) @(negedge clk);
        check("halt_no_scan", 64'(n_pulse - r), 64'd0);
        check("overrun_sticky", overrun, 1);
        tick_on = 0; gaps = 1; b2b_chk = 0;

        // Single-byte program and scan counter wrap
        mode = 2'd0;
        do_reset(16'h03FF, 16'h03FF);
        wait_scans(2, 100);
        mode = 2'd3;
        repeat (10) @(negedge clk);
        check("halt_idle", busy, 0);
        force dut.scan_cnt = 16'hFFFF;
        #1 release dut.scan_cnt;
        m_cnt = 16'hFFFF;
        n = scans_done + 1;
        mode = 2'd0;
        wait_scans(n, 100);
        check("cnt_wrap", scan_cnt, 16'h0000);

        // Random headers with junk above ADDR_W, continuous mode
        b2b_chk = 1;
        for (int k = 0; k < 4; k++) begin
            st  = $urandom_range(4, 300);
            len = $urandom_range(1, 24);
            hs  = 16'(st) | (16'($urandom_range(0, 63)) << 10);
            he  = 16'(st + len - 1) | (16'($urandom_range(0, 63)) << 10);
            do_reset(hs, he);
            wait_scans(3, 400);
            check("rand_instr_count", n_instr, 3 * len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
